serial_deserializer: RTL and testbench
======================================

# serial_deserializer

Serial-to-parallel capture stage that sits directly downstream of the edge-triggered D flip-flop. It consumes the flip-flop's registered `q` output as a framed serial line: idle high, start bit 0, WIDTH data bits LSB-first, optional parity bit, stop bit 1. Each good frame is assembled into a parallel word and presented on a one-entry valid/ready output register. Framing and overrun faults are reported as single-cycle pulses.

## Interface
- `WIDTH`, default 8: data bits per frame; legal range 2..16.
- `clk` input 1: rising-edge clock, shared with the upstream flip-flop.
- `clear` input 1: reset, asynchronous, active-low (0 = reset).
- `din` input 1: serial line, driven from the upstream flip-flop `q`.
- `din_en` input 1: sample strobe; `din` is evaluated only on edges where `din_en`=1.
- `data_out` output WIDTH: last accepted frame's data.
- `data_valid` output 1: `data_out` holds an unconsumed word.
- `data_ready` input 1: downstream accepts the word.
- `framing_err` output 1: one-cycle pulse; stop bit sampled as 0.
- `parity_err` output 1: one-cycle pulse; parity mismatch (see Configuration).
- `overrun` output 1: one-cycle pulse; a good frame was dropped because the output slot was full.

## Operation
- States:
  - IDLE: on a `din_en` edge with `din`=0, go to SHIFT and set bit_cnt=0. `din`=1 stays in IDLE.
  - SHIFT: on each `din_en` edge, shift `din` into the shift register MSB-side, so after WIDTH bits bit 0 is the first received bit. bit_cnt increments. After bit WIDTH-1, go to PARITY if the parity macro is defined, otherwise go to STOP.
  - PARITY: on a `din_en` edge, latch the parity bit and go to STOP.
  - STOP: on a `din_en` edge, go to IDLE.
    - `din`=1 (good frame): deliver the word, subject to the overrun rule.
    - `din`=0: pulse `framing_err` and discard the word.
- Edges with `din_en`=0 hold all state, the shift register, and bit_cnt.
- bit_cnt width is clog2(WIDTH). It never wraps past WIDTH-1.
- Output slot and delivery, for a good stop:
  - Slot empty, or (`data_valid`=1 and `data_ready`=1) on the same edge: load `data_out` and set `data_valid`=1.
  - `data_valid`=1 and `data_ready`=0: drop the word. `data_out` and `data_valid` are unchanged, and `overrun` pulses.
- Handshake: a transfer occurs on a rising edge with `data_valid`=1 and `data_ready`=1. If no new word loads on that edge, `data_valid` clears.
- `data_out` is stable while `data_valid`=1 and `data_ready`=0.
- Priority on a bad stop with a parity error:
  - `framing_err` pulses.
  - `parity_err` is suppressed.
  - The word is discarded.
- Asynchronous reset (`clear`=0), including mid-frame, forces:
  - state IDLE, bit_cnt 0, shift register 0;
  - `data_out` 0, `data_valid` 0;
  - `framing_err`, `parity_err`, `overrun` all 0.
- A partial frame is lost on reset. Reception resumes with the first start bit sampled after `clear` returns to 1.

## Timing
- All state updates occur on the rising `clk` edge.
- Reset acts immediately, independent of `clk`.
- Latency: `data_valid` and `data_out` update on the same edge that samples a good stop bit, so they are visible in the following cycle.
- A frame occupies 10 `din_en` samples (WIDTH=8, no parity) or 11 samples (with parity).
- Error pulses (`framing_err`, `parity_err`, `overrun`):
  - Each is high for exactly one `clk` cycle, following the stop-sample edge.
  - Each is independent of `din_en` on the next cycle.
- Back-to-back frames: a start bit may be sampled on the first `din_en` edge after the stop edge.
- No combinational path exists from `data_ready` or `din` to any output.

## Configuration
- `SERIAL_DESER_PARITY_EN` defined:
  - Frames carry one even-parity bit between the data bits and the stop bit; the PARITY state exists.
  - On a good stop where the XOR of the data bits and the parity bit is 1, `parity_err` pulses and the word is discarded. No delivery and no `overrun` occur.
- Undefined:
  - The PARITY state is not built.
  - `parity_err` is tied to 0.
  - The frame length is WIDTH+2.

## Test plan
- Reset: hold `clear`=0 while `din` toggles. Expect all outputs at 0 and the state at IDLE. After release, with `din`=1 steady, `data_valid` stays 0.
- Good frame: WIDTH=8, no parity, `din_en`=1 every cycle, `data_ready`=0. Drive `din` = 0,1,0,1,0,0,1,0,1,1. Expect `data_out`=0xA5 and `data_valid`=1 after the 10th edge, with no error pulses.
- Framing error: send 0x3C with the stop bit forced to 0. Expect one `framing_err` pulse, `data_valid` to remain 0, and the next frame, 0x81, to be received correctly.
- Overrun and simultaneous accept:
  - With 0xA5 held and `data_ready`=0, a second frame 0x5A completes. Expect an `overrun` pulse and `data_out` to stay 0xA5.
  - Repeat with `data_ready`=1 on the stop edge. Expect `data_out`=0x5A, `data_valid` held at 1, and no overrun.
- Mid-frame reset: assert `clear`=0 after 4 data bits, then release and send 0xFF. Expect only 0xFF to be delivered.
- Parity (macro defined): send 0x07 with parity bit 1 → delivered, no error. Send 0x07 with parity bit 0 → one `parity_err` pulse, no delivery.

Source files
------------

// File: rtl/serial_deserializer.sv
// -----------------------------------------------------------------------------
// serial_deserializer
//
// Serial-to-parallel capture stage fed by the registered q output of an
// upstream flip-flop. The line is idle high; a frame is a start bit (0),
// WIDTH data bits LSB-first, an optional even-parity bit and a stop bit (1).
// Good frames land in a one-entry valid/ready output register; framing,
// parity and overrun faults are reported as one-cycle pulses.
//
// Optional feature macro: SERIAL_DESER_PARITY_EN
//   defined   : frames carry an even-parity bit before the stop bit
//   undefined : no parity bit, parity_err is tied to 0
//
// Ports
//   clk         in   rising-edge clock
//   clear       in   asynchronous reset, active low
//   din         in   serial line
//   din_en      in   sample strobe, din is only evaluated when 1
//   data_out    out  [WIDTH-1:0] last accepted word
//   data_valid  out  data_out holds an unconsumed word
//   data_ready  in   downstream accepts the word
//   framing_err out  one-cycle pulse, stop bit sampled as 0
//   parity_err  out  one-cycle pulse, parity mismatch on a good stop
//   overrun     out  one-cycle pulse, good word dropped (slot full)
// -----------------------------------------------------------------------------
module serial_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             din,
    input  logic             din_en,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             framing_err,
    output logic             parity_err,
    output logic             overrun
);

    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef SERIAL_DESER_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_STOP  = 2'd3
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             framing_err_q, framing_err_d;
    logic             overrun_q, overrun_d;
    logic             parity_bad;

`ifdef SERIAL_DESER_PARITY_EN
    logic             par_q, par_d;
    logic             parity_err_q, parity_err_d;

    // Even parity: data bits XOR parity bit must be 0.
    assign parity_bad = (^shift_q) ^ par_q;
`else
    assign parity_bad = 1'b0;
`endif

    // Next-state, shift path and output slot.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        data_out_d    = data_out_q;
        framing_err_d = 1'b0;
        overrun_d     = 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
        par_d         = par_q;
        parity_err_d  = 1'b0;
`endif
        // A handshake empties the slot unless a new word loads on the same edge.
        data_valid_d  = (data_valid_q && data_ready) ? 1'b0 : data_valid_q;

        if (din_en) begin
            case (state_q)
                S_IDLE: begin
                    if (!din) begin
                        state_d   = S_SHIFT;
                        bit_cnt_d = '0;
                    end
                end
                S_SHIFT: begin
                    // Shift in from the MSB side so the first bit ends at bit 0.
                    shift_d = {din, shift_q[WIDTH-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef SERIAL_DESER_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
`ifdef SERIAL_DESER_PARITY_EN
                S_PARITY: begin
                    par_d   = din;
                    state_d = S_STOP;
                end
`endif
                S_STOP: begin
                    state_d = S_IDLE;
                    // A bad stop bit outranks any parity fault.
                    if (!din) begin
                        framing_err_d = 1'b1;
                    end else if (parity_bad) begin
`ifdef SERIAL_DESER_PARITY_EN
                        parity_err_d = 1'b1;
`endif
                    end else if (data_valid_q && !data_ready) begin
                        overrun_d = 1'b1;
                    end else begin
                        data_out_d   = shift_q;
                        data_valid_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
            par_q         <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
`ifdef SERIAL_DESER_PARITY_EN
            par_q         <= par_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign framing_err = framing_err_q;
    assign overrun     = overrun_q;
`ifdef SERIAL_DESER_PARITY_EN
    assign parity_err  = parity_err_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// -----------------------------------------------------------------------------
// tb_serial_deserializer
//
// Scoreboard bench for serial_deserializer (WIDTH=8). Stimulus builds frames
// bit by bit and predicts, per frame, whether the word is delivered or which
// fault pulse appears; a separate monitor pops the predictions and compares
// them against the outputs. Honours SERIAL_DESER_PARITY_EN like the design.
// -----------------------------------------------------------------------------
module tb_serial_deserializer;

    localparam int W = 8;

    logic         clk;
    logic         clear;
    logic         din;
    logic         din_en;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         data_ready;
    logic         framing_err;
    logic         parity_err;
    logic         overrun;

    serial_deserializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .clear      (clear),
        .din        (din),
        .din_en     (din_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .framing_err(framing_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   cyc;
        logic fe;
        logic pe;
        logic ov;
    } pend_t;

    logic [W-1:0] exp_q[$];   // words expected to leave through the handshake
    pend_t        pend_q[$];  // expected fault pulses, tagged with their cycle
    bit           model_full; // reference view of the output slot
    int           rdy_mode;   // 0: ready low, 1: ready high, 2: random
    int           max_gap;    // max din_en=0 cycles inserted before each bit
    bit           mon_en;
    int           checks = 0;
    int           errors = 0;
    pend_t        e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs and advance the reference model for that edge.
    task automatic step(input logic d, input logic en, input bit is_stop,
                        input logic [W-1:0] word, input bit par_ok);
        logic  rdy;
        bit    load;
        pend_t p;
        rdy = (rdy_mode == 0) ? 1'b0 : (rdy_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        din        = d;
        din_en     = en;
        data_ready = rdy;
        load = 1'b0;
        p.cyc = cyc + 1;
        p.fe = 1'b0; p.pe = 1'b0; p.ov = 1'b0;
        if (en && is_stop) begin
            if (!d)                      p.fe = 1'b1;
            else if (!par_ok)            p.pe = 1'b1;
            else if (model_full && !rdy) p.ov = 1'b1;
            else                         load = 1'b1;
            if (p.fe || p.pe || p.ov) pend_q.push_back(p);
        end
        if (load) begin
            exp_q.push_back(word);
            model_full = 1'b1;
        end else if (model_full && rdy) begin
            model_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sample_bit(input logic b, input bit is_stop, input logic [W-1:0] word,
                              input bit par_ok);
        int g;
        g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        for (int i = 0; i < g; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, '0, 1'b1);
        step(b, 1'b1, is_stop, word, par_ok);
    endtask

    // stop_rdy >= 0 forces data_ready on the stop sample.
    task automatic send_frame(input logic [W-1:0] word, input logic stop_bit,
                              input logic par_bit, input int stop_rdy);
        bit par_ok;
        int saved;
`ifdef SERIAL_DESER_PARITY_EN
        par_ok = ((^word) ^ par_bit) == 1'b0;
`else
        par_ok = 1'b1;
        if (par_bit) par_ok = 1'b1;
`endif
        sample_bit(1'b0, 1'b0, word, par_ok);
        for (int i = 0; i < W; i++) sample_bit(word[i], 1'b0, word, par_ok);
`ifdef SERIAL_DESER_PARITY_EN
        sample_bit(par_bit, 1'b0, word, par_ok);
`endif
        saved = rdy_mode;
        if (stop_rdy >= 0) rdy_mode = stop_rdy;
        sample_bit(stop_bit, 1'b1, word, par_ok);
        rdy_mode = saved;
    endtask

    function automatic logic even_par(input logic [W-1:0] w);
        return ^w;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, '0, 1'b1);
    endtask

    // Monitor: fault pulses every cycle, words on every handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            if (pend_q.size() > 0 && pend_q[0].cyc == cyc) begin
                e = pend_q.pop_front();
                chk("fault_pulses", {29'd0, framing_err, parity_err, overrun}, {29'd0, e.fe, e.pe, e.ov});
            end else begin
                chk("no_pulse", {29'd0, framing_err, parity_err, overrun}, 32'd0);
            end
            if (data_valid && data_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%0h expected none (t=%0t)", data_out, $time);
                end else begin
                    chk("word", 32'(data_out), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w;
        logic         sb;
        logic         pb;
        clear = 1'b1; din = 1'b1; din_en = 1'b0; data_ready = 1'b0;
        model_full = 1'b0; rdy_mode = 0; max_gap = 0; mon_en = 1'b0;
        #3 clear = 1'b0;
        mon_en = 1'b1;

        // Reset held while the line toggles.
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            step(1'(i), 1'b1, 1'b0, '0, 1'b1);
            chk("rst_valid", 32'(data_valid), 0);
            chk("rst_data", 32'(data_out), 0);
        end
        clear = 1'b1;
        idle(5);
        chk("post_rst_valid", 32'(data_valid), 0);

        // 0xA5, ready low, then 0x5A overruns.
        send_frame(8'hA5, 1'b1, even_par(8'hA5), -1);
        chk("a5_valid", 32'(data_valid), 1);
        chk("a5_data", 32'(data_out), 32'hA5);
        send_frame(8'h5A, 1'b1, even_par(8'h5A), -1);
        chk("ovr_hold", 32'(data_out), 32'hA5);
        // Same again but accepted on the stop edge.
        send_frame(8'h5A, 1'b1, even_par(8'h5A), 1);
        chk("acc_data", 32'(data_out), 32'h5A);
        chk("acc_valid", 32'(data_valid), 1);
        rdy_mode = 1;
        idle(3);

        // Framing error followed by a good frame.
        send_frame(8'h3C, 1'b0, even_par(8'h3C), -1);
        chk("fe_valid", 32'(data_valid), 0);
        send_frame(8'h81, 1'b1, even_par(8'h81), -1);
        idle(2);

        // Mid-frame reset after four data bits.
        step(1'b0, 1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'(i), 1'b1, 1'b0, '0, 1'b1);
        clear = 1'b0;
        exp_q.delete();
        model_full = 1'b0;
        #1 chk("mid_rst_valid", 32'(data_valid), 0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        clear = 1'b1;
        idle(2);
        send_frame(8'hFF, 1'b1, even_par(8'hFF), -1);
        idle(2);

`ifdef SERIAL_DESER_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, -1);
        send_frame(8'h07, 1'b1, 1'b0, -1);
        idle(2);
`endif

        // Randomized frames, gaps and back-pressure.
        rdy_mode = 2;
        max_gap  = 2;
        for (int n = 0; n < 60; n++) begin
            w  = W'($urandom);
            sb = ($urandom_range(0, 9) != 0);
            pb = even_par(w) ^ ($urandom_range(0, 3) == 0);
            send_frame(w, sb, pb, -1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        // Drain and confirm every prediction was consumed.
        rdy_mode = 1;
        max_gap  = 0;
        idle(6);
        chk("exp_q_drained", 32'(exp_q.size()), 0);
        chk("pend_q_drained", 32'(pend_q.size()), 0);
        chk("final_valid", 32'(data_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
